nibble_serial_subtractor: RTL and testbench
===========================================

NIBBLE_SERIAL_SUBTRACTOR -- requirements
Module: nibble_serial_subtractor

Interface
REQ-001 The block SHALL have exactly one parameter: WIDTH, default 16, operand width in bits; multiple of 4, minimum 8.
REQ-002 The port clk SHALL be an input, 1 bit wide: the single clock; all state updates on the rising edge.
REQ-003 The port rst_n SHALL be an input, 1 bit wide: reset, asynchronous and active-low.
REQ-004 The port in_valid SHALL be an input, 1 bit wide: operands valid.
REQ-005 The port in_ready SHALL be an output, 1 bit wide: the block can accept operands.
REQ-006 The port A SHALL be an input, WIDTH bits wide: the minuend.
REQ-007 The port B SHALL be an input, WIDTH bits wide: the subtrahend.
REQ-008 The port Bin SHALL be an input, 1 bit wide: borrow-in.
REQ-009 The port out_valid SHALL be an output, 1 bit wide: result valid.
REQ-010 The port out_ready SHALL be an input, 1 bit wide: the consumer accepts the result.
REQ-011 The port Diff SHALL be an output, WIDTH bits wide: the result A - B - Bin, modulo 2^WIDTH.
REQ-012 The port Bout SHALL be an output, 1 bit wide: borrow-out; 1 when A < B + Bin, unsigned.
REQ-013 The port Ovf SHALL be an output, 1 bit wide: signed overflow; present only when SUB_OVF_EN is defined.

Function
REQ-014 The FSM SHALL have states IDLE, CALC and DONE, and no others.
REQ-015 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-016 Input accept SHALL occur on an edge with in_valid=1 and in_ready=1; A, B and Bin are latched internally, nibble counter := 0, state -> CALC.
REQ-017 In CALC, each edge SHALL process one 4-bit nibble, LSB nibble first, using borrow-lookahead within the nibble.
REQ-018 The borrow-lookahead SHALL use generate g_i = ~a_i & b_i and propagate p_i = ~(a_i ^ b_i), with borrow_{i+1} = g_i | (p_i & borrow_i).
REQ-019 The nibble result SHALL be written into the Diff register; the nibble borrow-out SHALL be registered as the next nibble's borrow-in; the first nibble uses the latched Bin.
REQ-020 After WIDTH/4 CALC edges, state SHALL go -> DONE; the final registered borrow drives Bout.
REQ-021 Latency SHALL be: out_valid rises exactly WIDTH/4 cycles after the accept edge (4 cycles at default WIDTH).
REQ-022 In DONE, Diff, Bout and Ovf SHALL be held stable while out_ready=0 (backpressure of unlimited length).
REQ-023 A DONE edge with out_ready=1 SHALL take state -> IDLE; there is no accept on that same edge; the earliest next accept is the following edge.
REQ-024 Input changes during CALC or DONE SHALL be ignored; only the latched operands are used.
REQ-025 Diff SHALL hold its last result in IDLE until the next accept overwrites it nibble by nibble; its value is only meaningful while out_valid=1.
REQ-026 in_valid=1 during reset SHALL NOT be accepted until the first edge after rst_n deasserts.

Reset
REQ-027 With rst_n=0, the block SHALL immediately, without waiting for a clock, force state=IDLE, in_ready=1, out_valid=0, Diff=0, Bout=0, Ovf=0, and counter and internal borrow to 0.
REQ-028 Reset asserted mid-CALC or in DONE SHALL abort the operation; no partial result is flagged valid.

Configuration
REQ-029 Feature macro SUB_OVF_EN SHALL control the Ovf port as follows.
REQ-030 When SUB_OVF_EN is defined, the Ovf port and its logic SHALL exist; Ovf is registered on entry to DONE as (A[MSB] != B[MSB]) & (Diff[MSB] != A[MSB]), using the latched operands, and is held in DONE like Diff.
REQ-031 When SUB_OVF_EN is not defined, the Ovf port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-032 Basic: A=0x1234, B=0x0234, Bin=0 -> after 4 cycles out_valid=1, Diff=0x1000, Bout=0.
REQ-033 Full borrow ripple: A=0x0000, B=0x0001, Bin=0 -> Diff=0xFFFF, Bout=1, with the borrow crossing all nibble boundaries.
REQ-034 Borrow-in: A=0x0010, B=0x0000, Bin=1 -> Diff=0x000F, Bout=0; A=0x0000, B=0xFFFF, Bin=1 -> Diff=0x0000, Bout=1.
REQ-035 Overflow (SUB_OVF_EN defined): A=0x8000, B=0x0001 -> Diff=0x7FFF, Ovf=1; A=0x7FFF, B=0x0001 -> Ovf=0.
REQ-036 Handshake: hold out_ready=0 for 10 cycles in DONE -> Diff and out_valid stable and in_ready=0; in_valid pulsed during CALC -> ignored; back-to-back ops -> exactly one idle cycle between result handoff and next accept.
REQ-037 Reset mid-op: assert rst_n=0 after 2 CALC edges -> outputs go to reset values immediately; the next op, A=0x0005, B=0x0003, yields Diff=0x0002.

Source files
------------

// File: rtl/nibble_serial_subtractor.sv
// Nibble-serial subtractor: Diff = A - B - Bin, one 4-bit nibble per cycle.
// Optional signed overflow output Ovf is enabled by defining SUB_OVF_EN.
module nibble_serial_subtractor #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Diff,
`ifdef SUB_OVF_EN
    output logic             Bout,
    output logic             Ovf
`else
    output logic             Bout
`endif
);

    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CW-1:0] LAST = CW'(NIB - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] diff_q;
    logic [CW-1:0]    cnt;
    logic             borrow_q;
    logic             accept;
    logic             last;

    logic [3:0] na, nb, g, p, nd;
    logic [4:0] c;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next state and handshake outputs
    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = CALC;
            end
            CALC: begin
                if (cnt == LAST) state_nx = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign accept = (state == IDLE) && in_valid;
    assign last   = (state == CALC) && (cnt == LAST);

    // Borrow-lookahead over the current nibble
    always_comb begin
        na   = a_q[cnt*4 +: 4];
        nb   = b_q[cnt*4 +: 4];
        g    = ~na & nb;
        p    = ~(na ^ nb);
        c[0] = borrow_q;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & c[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c[0]);
        nd   = na ^ nb ^ c[3:0];
    end

    // Operand latch, nibble counter, result and borrow chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            cnt      <= '0;
            borrow_q <= 1'b0;
        end else if (accept) begin
            a_q      <= A;
            b_q      <= B;
            cnt      <= '0;
            borrow_q <= Bin;
        end else if (state == CALC) begin
            diff_q[cnt*4 +: 4] <= nd;
            borrow_q           <= c[4];
            cnt                <= cnt + 1'b1;
        end
    end

    assign Diff = diff_q;
    assign Bout = borrow_q;

`ifdef SUB_OVF_EN
    logic ovf_q;

    // Signed overflow captured on the final nibble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    ovf_q <= 1'b0;
        else if (last) ovf_q <= (a_q[WIDTH-1] != b_q[WIDTH-1])
                              & (nd[3] != a_q[WIDTH-1]);
    end

    assign Ovf = ovf_q;
`else
    logic unused_last;
    assign unused_last = last;
`endif

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Directed self-checking bench for nibble_serial_subtractor (WIDTH=16).
// Define SUB_OVF_EN to include the overflow vectors.
module tb_nibble_serial_subtractor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        bin = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] diff;
    logic        bout;
`ifdef SUB_OVF_EN
    logic        ovf;
`endif

    int checks = 0;
    int errors = 0;

    nibble_serial_subtractor #(.WIDTH(16)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .A(a),
        .B(b),
        .Bin(bin),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .Diff(diff),
`ifdef SUB_OVF_EN
        .Bout(bout),
        .Ovf(ovf)
`else
        .Bout(bout)
`endif
    );

    always #5 clk = ~clk;

    // Present operands and hold in_valid through one rising edge.
    task automatic start_op(input logic [15:0] ta, input logic [15:0] tb,
                            input logic tbin);
        a        = ta;
        b        = tb;
        bin      = tbin;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Count cycles until out_valid, bounded; lat = -1 on timeout.
    task automatic wait_result(output int lat);
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic run_vec(input string name, input logic [15:0] ta,
                           input logic [15:0] tb, input logic tbin,
                           input logic [15:0] ed, input logic eb);
        int lat;
        start_op(ta, tb, tbin);
        wait_result(lat);
        checks++;
        if (lat !== 4) begin
            errors++;
            $display("FAIL %s latency: got %0d want 4", name, lat);
        end
        checks++;
        if (diff !== ed) begin
            errors++;
            $display("FAIL %s Diff: got %h want %h", name, diff, ed);
        end
        checks++;
        if (bout !== eb) begin
            errors++;
            $display("FAIL %s Bout: got %b want %b", name, bout, eb);
        end
        release_result();
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        in_valid = 1'b1;
        a        = 16'h1111;
        b        = 16'h0001;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 ||
            diff !== 16'h0000 || bout !== 1'b0) begin
            errors++;
            $display("FAIL reset_vals: rdy=%b vld=%b diff=%h bout=%b want 1 0 0000 0",
                     in_ready, out_valid, diff, bout);
        end
`ifdef SUB_OVF_EN
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_ovf: got %b want 0", ovf);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b want 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL first_edge_accept: in_ready=%b want 0", in_ready);
        end
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_basic();
        run_vec("basic",   16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0);
        run_vec("mixed",   16'hABCD, 16'h1234, 1'b0, 16'h9999, 1'b0);
        run_vec("neg",     16'h1234, 16'hABCD, 1'b0, 16'h6667, 1'b1);
    endtask

    task automatic test_ripple();
        run_vec("ripple",  16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1);
    endtask

    task automatic test_borrow_in();
        run_vec("bin_a",   16'h0010, 16'h0000, 1'b1, 16'h000F, 1'b0);
        run_vec("bin_b",   16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b1);
    endtask

`ifdef SUB_OVF_EN
    task automatic test_overflow();
        int lat;
        start_op(16'h8000, 16'h0001, 1'b0);
        wait_result(lat);
        checks++;
        if (lat !== 4 || diff !== 16'h7FFF || ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set: lat=%0d diff=%h ovf=%b want 4 7fff 1",
                     lat, diff, ovf);
        end
        release_result();
        start_op(16'h7FFF, 16'h0001, 1'b0);
        wait_result(lat);
        checks++;
        if (lat !== 4 || diff !== 16'h7FFE || ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clr: lat=%0d diff=%h ovf=%b want 4 7ffe 0",
                     lat, diff, ovf);
        end
        release_result();
    endtask
`endif

    task automatic test_backpressure();
        int lat;
        int bad = 0;
        start_op(16'h5555, 16'h1111, 1'b0);
        wait_result(lat);
        in_valid = 1'b1;
        a        = 16'hFFFF;
        b        = 16'hFFFF;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
                diff !== 16'h4444 || bout !== 1'b0)
                bad++;
        end
        in_valid = 1'b0;
        checks++;
        if (lat !== 4 || bad !== 0) begin
            errors++;
            $display("FAIL backpressure: lat=%0d unstable_cycles=%0d want 4 0",
                     lat, bad);
        end
        release_result();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL handoff: vld=%b rdy=%b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_calc_ignore();
        int lat;
        start_op(16'h0F0F, 16'h0101, 1'b0);
        @(posedge clk);
        #1;
        a        = 16'h0000;
        b        = 16'hFFFF;
        bin      = 1'b1;
        in_valid = 1'b1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL calc_ready: got %b want 0", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_result(lat);
        checks++;
        if (lat !== 2 || diff !== 16'h0E0E || bout !== 1'b0) begin
            errors++;
            $display("FAIL calc_ignore: lat=%0d diff=%h bout=%b want 2 0e0e 0",
                     lat, diff, bout);
        end
        release_result();
    endtask

    task automatic test_back_to_back();
        int lat;
        start_op(16'h0009, 16'h0004, 1'b0);
        wait_result(lat);
        a         = 16'h0100;
        b         = 16'h0001;
        bin       = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: rdy=%b vld=%b want 1 0", in_ready, out_valid);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_accept: rdy=%b want 0", in_ready);
        end
        wait_result(lat);
        checks++;
        if (lat !== 4 || diff !== 16'h00FF || bout !== 1'b0) begin
            errors++;
            $display("FAIL b2b_result: lat=%0d diff=%h bout=%b want 4 00ff 0",
                     lat, diff, bout);
        end
        release_result();
    endtask

    task automatic test_reset_mid_op();
        start_op(16'h0000, 16'h0001, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 ||
            diff !== 16'h0000 || bout !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: rdy=%b vld=%b diff=%h bout=%b want 1 0 0000 0",
                     in_ready, out_valid, diff, bout);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_hold: vld=%b want 0", out_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_vec("after_rst", 16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ripple();
        test_borrow_in();
`ifdef SUB_OVF_EN
        test_overflow();
`endif
        test_backpressure();
        test_calc_ignore();
        test_back_to_back();
        test_reset_mid_op();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
